// File: rtl/lzrw1_copy_ctrl.sv
// LZRW1 decoder back-end: emits literal bytes and expands copy items byte by byte from a history buffer.
// Optional offset checking with a sticky error_out port: define LZRW1_COPY_CTRL_ERR_CHECK_EN.
module lzrw1_copy_ctrl #(
   parameter int HIST_SIZE  = 4096,
   parameter int ADDR_WIDTH = $clog2(HIST_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  item_valid_in,
   output logic                  item_ready_out,
   input  logic                  item_is_copy_in,
   input  logic [7:0]            literal_in,
   input  logic [ADDR_WIDTH-1:0] offset_in,
   input  logic [3:0]            length_in,
   output logic                  hist_rd_en_out,
   output logic [ADDR_WIDTH-1:0] hist_rd_addr_out,
   input  logic [7:0]            hist_rd_data_in,
   output logic                  hist_wr_en_out,
   output logic [ADDR_WIDTH-1:0] hist_wr_addr_out,
   output logic [7:0]            hist_wr_data_out,
   output logic                  byte_valid_out,
   input  logic                  byte_ready_in,
   output logic [7:0]            byte_data_out
`ifdef LZRW1_COPY_CTRL_ERR_CHECK_EN
   ,
   output logic                  error_out
`endif
);

   // state | meaning
   // IDLE  | waiting for a literal or copy item
   // RD    | read strobe for the next copy byte
   // CAP   | capture history read data into the output register
   // OUT   | present byte, wait for downstream, then write it to history
   typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(HIST_SIZE - 1);
   localparam logic [ADDR_WIDTH:0]   HIST_SIZE_W = (ADDR_WIDTH + 1)'(HIST_SIZE);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
   logic [4:0]            r_remaining;
   logic [4:0]            w_remaining_nxt;
   logic                  r_is_copy;
   logic                  w_is_copy_nxt;
   logic [7:0]            r_byte_data;
   logic [7:0]            w_byte_data_nxt;
   logic                  w_offset_bad;
   logic                  w_byte_take;
   logic                  w_live;
   logic [ADDR_WIDTH-1:0] w_copy_start;

   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   assign w_live      = !reset;
   assign w_byte_take = (r_state == OUT) && byte_ready_in;

   // Copy source = write pointer minus distance, wrapped into the buffer without assuming a power-of-two depth.
   always_comb begin
      if (offset_in > r_wr_ptr)
         w_copy_start = ADDR_WIDTH'({1'b0, r_wr_ptr} + HIST_SIZE_W - {1'b0, offset_in});
      else
         w_copy_start = r_wr_ptr - offset_in;
   end

`ifdef LZRW1_COPY_CTRL_ERR_CHECK_EN
   logic [ADDR_WIDTH:0] r_wr_count;
   logic                r_error;
   logic                w_err_set;

   assign w_offset_bad = (offset_in == '0) || ({1'b0, offset_in} > r_wr_count);
   assign w_err_set    = (r_state == IDLE) && item_valid_in && item_is_copy_in && w_offset_bad;
   assign error_out    = r_error;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_count <= '0;
         r_error    <= 1'b0;
      end else begin
         if (w_byte_take && (r_wr_count != HIST_SIZE_W))
            r_wr_count <= r_wr_count + (ADDR_WIDTH + 1)'(1);
         if (w_err_set)
            r_error <= 1'b1;
      end
   end
`else
   assign w_offset_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_remaining <= '0;
         r_is_copy   <= 1'b0;
         r_byte_data <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_remaining <= w_remaining_nxt;
         r_is_copy   <= w_is_copy_nxt;
         r_byte_data <= w_byte_data_nxt;
      end
   end

   // Strobes are gated by reset so an aborted item never reads, writes or emits in the reset cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_wr_ptr_nxt     = r_wr_ptr;
      w_rd_ptr_nxt     = r_rd_ptr;
      w_remaining_nxt  = r_remaining;
      w_is_copy_nxt    = r_is_copy;
      w_byte_data_nxt  = r_byte_data;
      item_ready_out   = 1'b0;
      hist_rd_en_out   = 1'b0;
      hist_rd_addr_out = '0;
      hist_wr_en_out   = 1'b0;
      hist_wr_addr_out = '0;
      hist_wr_data_out = '0;
      byte_valid_out   = 1'b0;
      byte_data_out    = '0;
      unique case (r_state)
         IDLE: begin
            item_ready_out = w_live;
            if (item_valid_in) begin
               if (!item_is_copy_in) begin
                  w_byte_data_nxt = literal_in;
                  w_is_copy_nxt   = 1'b0;
                  w_state_nxt     = OUT;
               end else if (!w_offset_bad) begin
                  w_rd_ptr_nxt    = w_copy_start;
                  w_remaining_nxt = {1'b0, length_in} + 5'd3;
                  w_is_copy_nxt   = 1'b1;
                  w_state_nxt     = RD;
               end
            end
         end
         RD: begin
            hist_rd_en_out   = w_live;
            hist_rd_addr_out = w_live ? r_rd_ptr : '0;
            w_state_nxt      = CAP;
         end
         CAP: begin
            w_byte_data_nxt = hist_rd_data_in;
            w_state_nxt     = OUT;
         end
         OUT: begin
            byte_valid_out = w_live;
            byte_data_out  = w_live ? r_byte_data : '0;
            if (w_byte_take) begin
               hist_wr_en_out   = w_live;
               hist_wr_addr_out = w_live ? r_wr_ptr : '0;
               hist_wr_data_out = w_live ? r_byte_data : '0;
               w_wr_ptr_nxt     = ptr_inc(r_wr_ptr);
               // The write lands before the next RD, so overlapping copies see their own output.
               if (r_is_copy && (r_remaining > 5'd1)) begin
                  w_remaining_nxt = r_remaining - 5'd1;
                  w_rd_ptr_nxt    = ptr_inc(r_rd_ptr);
                  w_state_nxt     = RD;
               end else begin
                  w_remaining_nxt = '0;
                  w_state_nxt     = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_lzrw1_copy_ctrl.sv
// Testbench for lzrw1_copy_ctrl: history memory model, byte/address scoreboard, scenario tasks.
module tb_lzrw1_copy_ctrl;
   localparam int HIST = 4096;
   localparam int AW   = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          item_valid_in = 1'b0;
   logic          item_ready_out;
   logic          item_is_copy_in = 1'b0;
   logic [7:0]    literal_in = '0;
   logic [AW-1:0] offset_in = '0;
   logic [3:0]    length_in = '0;
   logic          hist_rd_en_out;
   logic [AW-1:0] hist_rd_addr_out;
   logic [7:0]    hist_rd_data_in;
   logic          hist_wr_en_out;
   logic [AW-1:0] hist_wr_addr_out;
   logic [7:0]    hist_wr_data_out;
   logic          byte_valid_out;
   logic          byte_ready_in = 1'b1;
   logic [7:0]    byte_data_out;
`ifdef LZRW1_COPY_CTRL_ERR_CHECK_EN
   logic          error_out;
`endif

   lzrw1_copy_ctrl #(.HIST_SIZE(HIST)) dut (
      .clk              (clk),
      .reset            (reset),
      .item_valid_in    (item_valid_in),
      .item_ready_out   (item_ready_out),
      .item_is_copy_in  (item_is_copy_in),
      .literal_in       (literal_in),
      .offset_in        (offset_in),
      .length_in        (length_in),
      .hist_rd_en_out   (hist_rd_en_out),
      .hist_rd_addr_out (hist_rd_addr_out),
      .hist_rd_data_in  (hist_rd_data_in),
      .hist_wr_en_out   (hist_wr_en_out),
      .hist_wr_addr_out (hist_wr_addr_out),
      .hist_wr_data_out (hist_wr_data_out),
      .byte_valid_out   (byte_valid_out),
      .byte_ready_in    (byte_ready_in),
      .byte_data_out    (byte_data_out)
`ifdef LZRW1_COPY_CTRL_ERR_CHECK_EN
      ,
      .error_out        (error_out)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rd_count = 0;
   int wr_count = 0;

   logic [7:0]    mem     [HIST];
   logic [7:0]    mdl_mem [HIST];
   logic [AW-1:0] mwp;
   logic [7:0]    exp_data  [$];
   logic [AW-1:0] exp_waddr [$];
   logic [AW-1:0] exp_raddr [$];
   int            acc_cyc   [$];

   // History RAM: one-cycle read latency.
   always @(posedge clk) begin
      cyc++;
      if (hist_wr_en_out) mem[hist_wr_addr_out] <= hist_wr_data_out;
      if (hist_rd_en_out) hist_rd_data_in <= mem[hist_rd_addr_out];
   end

   logic [7:0]    mon_d;
   logic [AW-1:0] mon_a;
   always @(negedge clk) begin
      if (!reset) begin
         if (hist_rd_en_out || hist_wr_en_out) begin
            checks++;
            if (hist_rd_en_out && hist_wr_en_out) begin
               failures++;
               $display("FAIL strobe_overlap rd_en=%b wr_en=%b required not both", hist_rd_en_out, hist_wr_en_out);
            end
         end
         if (hist_rd_en_out) begin
            rd_count++;
            checks++;
            if (exp_raddr.size() == 0) begin
               failures++;
               $display("FAIL unexpected_read addr=%0d required no read", hist_rd_addr_out);
            end else begin
               mon_a = exp_raddr.pop_front();
               if (hist_rd_addr_out !== mon_a) begin
                  failures++;
                  $display("FAIL read_addr got=%0d required=%0d", hist_rd_addr_out, mon_a);
               end
            end
         end
         if (byte_valid_out && byte_ready_in) begin
            wr_count++;
            acc_cyc.push_back(cyc + 1);
            checks++;
            if (exp_data.size() == 0) begin
               failures++;
               $display("FAIL unexpected_byte data=%h required no byte", byte_data_out);
            end else begin
               mon_d = exp_data.pop_front();
               mon_a = exp_waddr.pop_front();
               if (byte_data_out !== mon_d || hist_wr_en_out !== 1'b1 ||
                   hist_wr_addr_out !== mon_a || hist_wr_data_out !== mon_d) begin
                  failures++;
                  $display("FAIL byte data=%h wr_en=%b waddr=%0d wdata=%h required data=%h wr_en=1 waddr=%0d",
                           byte_data_out, hist_wr_en_out, hist_wr_addr_out, hist_wr_data_out, mon_d, mon_a);
               end
            end
         end else if (hist_wr_en_out) begin
            checks++;
            failures++;
            $display("FAIL stray_write addr=%0d required no write", hist_wr_addr_out);
         end
      end
   end

   task automatic model_literal(input logic [7:0] b);
      exp_data.push_back(b);
      exp_waddr.push_back(mwp);
      mdl_mem[mwp] = b;
      mwp = mwp + 1'b1;
   endtask

   task automatic model_copy(input logic [AW-1:0] off, input logic [3:0] len);
      logic [AW-1:0] rp;
      rp = mwp - off;
      for (int i = 0; i < int'(len) + 3; i++) begin
         exp_raddr.push_back(rp);
         model_literal(mdl_mem[rp]);
         rp = rp + 1'b1;
      end
   endtask

   task automatic flush_model();
      mwp = '0;
      exp_data.delete();
      exp_waddr.delete();
      exp_raddr.delete();
      acc_cyc.delete();
   endtask

   // Returns at posedge+1 of the accepting edge; acc = that edge's cycle number.
   task automatic send_item(input bit is_copy, input logic [7:0] lit, input logic [AW-1:0] off,
                            input logic [3:0] len, input bit use_model, output int acc);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!item_ready_out && n < 300);
      if (!item_ready_out) begin
         checks++;
         failures++;
         $display("FAIL send_ready_timeout item_ready_out=%b required 1", item_ready_out);
      end
      if (use_model) begin
         if (is_copy) model_copy(off, len);
         else         model_literal(lit);
      end
      item_valid_in   = 1'b1;
      item_is_copy_in = is_copy;
      literal_in      = lit;
      offset_in       = off;
      length_in       = len;
      @(posedge clk); #1;
      acc = cyc;
      item_valid_in   = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      int n;
      n = 0;
      while ((exp_data.size() != 0 || !item_ready_out) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      ok = (exp_data.size() == 0) && (exp_raddr.size() == 0) && item_ready_out;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      flush_model();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      byte_ready_in = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (item_ready_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b required=0", item_ready_out);
      end
      checks++;
      if ({hist_rd_en_out, hist_wr_en_out, byte_valid_out} !== 3'b000) begin
         failures++;
         $display("FAIL reset_strobes rd=%b wr=%b valid=%b required 0 0 0", hist_rd_en_out, hist_wr_en_out, byte_valid_out);
      end
      checks++;
      if (hist_rd_addr_out !== '0 || hist_wr_addr_out !== '0 || hist_wr_data_out !== 8'h00 || byte_data_out !== 8'h00) begin
         failures++;
         $display("FAIL reset_addr_data raddr=%0d waddr=%0d wdata=%h bdata=%h required all 0",
                  hist_rd_addr_out, hist_wr_addr_out, hist_wr_data_out, byte_data_out);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      flush_model();
      @(negedge clk);
      checks++;
      if (item_ready_out !== 1'b1) begin
         failures++;
         $display("FAIL idle_ready got=%b required=1", item_ready_out);
      end
   endtask

   task automatic test_literals();
      int a;
      int t0;
      bit ok;
      logic [7:0] b;
      acc_cyc.delete();
      t0 = 0;
      for (int i = 0; i < 3; i++) begin
         b = 8'(8'h41 + i);
         send_item(1'b0, b, '0, '0, 1'b1, a);
         if (i == 0) t0 = a;
         @(negedge clk);
         checks++;
         if (byte_valid_out !== 1'b1 || byte_data_out !== b) begin
            failures++;
            $display("FAIL literal_latency valid=%b data=%h required valid=1 data=%h", byte_valid_out, byte_data_out, b);
         end
      end
      wait_done(ok);
      checks++;
      if (!ok || acc_cyc.size() != 3) begin
         failures++;
         $display("FAIL literal_drain ok=%b bytes=%0d required ok=1 bytes=3", ok, acc_cyc.size());
      end else begin
         checks++;
         if (acc_cyc[0] != t0 + 1 || acc_cyc[1] - acc_cyc[0] != 2 || acc_cyc[2] - acc_cyc[1] != 2) begin
            failures++;
            $display("FAIL literal_rate first=%0d gaps=%0d,%0d required first=%0d gaps=2,2",
                     acc_cyc[0] - t0, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1], 1);
         end
      end
   endtask

   task automatic test_copy_basic();
      int a;
      bit ok;
      acc_cyc.delete();
      send_item(1'b1, 8'h00, 12'd3, 4'd0, 1'b1, a);
      wait_done(ok);
      checks++;
      if (!ok || acc_cyc.size() != 3) begin
         failures++;
         $display("FAIL copy_drain ok=%b bytes=%0d required ok=1 bytes=3", ok, acc_cyc.size());
      end else begin
         checks++;
         if (acc_cyc[0] != a + 3 || acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
            failures++;
            $display("FAIL copy_rate first=%0d gaps=%0d,%0d required first=3 gaps=3,3",
                     acc_cyc[0] - a, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      int a;
      int n;
      int rd0;
      int wr0;
      bit ok;
      bit bad;
      logic [7:0] d;
      byte_ready_in = 1'b0;
      send_item(1'b1, 8'h00, 12'd2, 4'd0, 1'b1, a);
      n = 0;
      while (!byte_valid_out && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!byte_valid_out || byte_data_out !== exp_data[0]) begin
         failures++;
         $display("FAIL bp_first valid=%b data=%h required valid=1 data=%h", byte_valid_out, byte_data_out, exp_data[0]);
      end
      d = byte_data_out;
      rd0 = rd_count;
      wr0 = wr_count;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (byte_data_out !== d || byte_valid_out !== 1'b1 || hist_wr_en_out !== 1'b0 || hist_rd_en_out !== 1'b0)
            bad = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL bp_hold data=%h valid=%b wr=%b rd=%b required data=%h valid=1 wr=0 rd=0",
                  byte_data_out, byte_valid_out, hist_wr_en_out, hist_rd_en_out, d);
      end
      byte_ready_in = 1'b1;
      wait_done(ok);
      checks++;
      if (!ok || wr_count - wr0 != 3 || rd_count - rd0 != 2) begin
         failures++;
         $display("FAIL bp_counts ok=%b writes=%0d reads=%0d required ok=1 writes=3 reads=2", ok, wr_count - wr0, rd_count - rd0);
      end
   endtask

   task automatic test_overlap();
      int a;
      int rd0;
      int wr0;
      bit ok;
      do_reset();
      rd0 = rd_count;
      wr0 = wr_count;
      send_item(1'b0, 8'h55, '0, '0, 1'b1, a);
      send_item(1'b1, 8'h00, 12'd1, 4'd15, 1'b1, a);
      wait_done(ok);
      checks++;
      if (!ok || wr_count - wr0 != 19 || rd_count - rd0 != 18) begin
         failures++;
         $display("FAIL overlap_counts ok=%b writes=%0d reads=%0d required ok=1 writes=19 reads=18", ok, wr_count - wr0, rd_count - rd0);
      end
      send_item(1'b0, 8'h66, '0, '0, 1'b1, a);
      @(negedge clk);
      checks++;
      if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== 12'd19) begin
         failures++;
         $display("FAIL overlap_wr_ptr wr_en=%b addr=%0d required wr_en=1 addr=19", hist_wr_en_out, hist_wr_addr_out);
      end
      wait_done(ok);
   endtask

   task automatic test_wrap();
      int a;
      bit ok;
      logic [AW-1:0] wa [4];
      wa[0] = 12'd4094;
      wa[1] = 12'd4095;
      wa[2] = 12'd0;
      wa[3] = 12'd1;
      do_reset();
      for (int i = 0; i < 4094; i++)
         send_item(1'b0, 8'(i), '0, '0, 1'b1, a);
      for (int i = 0; i < 4; i++) begin
         send_item(1'b0, 8'(8'hA0 + i), '0, '0, 1'b1, a);
         @(negedge clk);
         checks++;
         if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== wa[i]) begin
            failures++;
            $display("FAIL wrap_write%0d wr_en=%b addr=%0d required wr_en=1 addr=%0d", i, hist_wr_en_out, hist_wr_addr_out, wa[i]);
         end
      end
      send_item(1'b1, 8'h00, 12'd3, 4'd0, 1'b1, a);
      @(negedge clk);
      checks++;
      if (hist_rd_en_out !== 1'b1 || hist_rd_addr_out !== 12'd4095) begin
         failures++;
         $display("FAIL wrap_read rd_en=%b addr=%0d required rd_en=1 addr=4095", hist_rd_en_out, hist_rd_addr_out);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wrap_drain pending=%0d required 0", exp_data.size());
      end
   endtask

   task automatic test_reset_midcopy();
      int a;
      int n;
      int w0;
      bit bad;
      do_reset();
      send_item(1'b0, 8'h11, '0, '0, 1'b1, a);
      send_item(1'b0, 8'h22, '0, '0, 1'b1, a);
      send_item(1'b0, 8'h33, '0, '0, 1'b1, a);
      w0 = wr_count + 1;
      send_item(1'b1, 8'h00, 12'd3, 4'd15, 1'b1, a);
      n = 0;
      while (wr_count < w0 + 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({hist_rd_en_out, hist_wr_en_out, byte_valid_out, item_ready_out} !== 4'b0000) begin
         failures++;
         $display("FAIL abort_reset_cycle rd=%b wr=%b valid=%b ready=%b required 0 0 0 0",
                  hist_rd_en_out, hist_wr_en_out, byte_valid_out, item_ready_out);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      flush_model();
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (hist_rd_en_out || hist_wr_en_out || byte_valid_out || !item_ready_out) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL abort_quiet rd=%b wr=%b valid=%b ready=%b required 0 0 0 1",
                  hist_rd_en_out, hist_wr_en_out, byte_valid_out, item_ready_out);
      end
   endtask

   task automatic test_after_abort();
      int a;
      int wr0;
      bit ok;
      wr0 = wr_count;
      send_item(1'b0, 8'h77, '0, '0, 1'b1, a);
      send_item(1'b1, 8'h00, 12'd1, 4'd0, 1'b1, a);
      @(negedge clk);
      checks++;
      if (hist_rd_en_out !== 1'b1 || hist_rd_addr_out !== 12'd0) begin
         failures++;
         $display("FAIL post_abort_read rd_en=%b addr=%0d required rd_en=1 addr=0", hist_rd_en_out, hist_rd_addr_out);
      end
      wait_done(ok);
      checks++;
      if (!ok || wr_count - wr0 != 4) begin
         failures++;
         $display("FAIL post_abort_drain ok=%b writes=%0d required ok=1 writes=4", ok, wr_count - wr0);
      end
   endtask

`ifdef LZRW1_COPY_CTRL_ERR_CHECK_EN
   task automatic test_err_check();
      int a;
      int wr0;
      bit ok;
      do_reset();
      @(negedge clk);
      checks++;
      if (error_out !== 1'b0) begin
         failures++;
         $display("FAIL err_reset got=%b required=0", error_out);
      end
      send_item(1'b0, 8'h01, '0, '0, 1'b1, a);
      send_item(1'b0, 8'h02, '0, '0, 1'b1, a);
      wait_done(ok);
      wr0 = wr_count;
      send_item(1'b1, 8'h00, 12'd5, 4'd0, 1'b0, a);
      @(negedge clk);
      checks++;
      if (error_out !== 1'b1 || item_ready_out !== 1'b1 || byte_valid_out !== 1'b0 || hist_rd_en_out !== 1'b0) begin
         failures++;
         $display("FAIL err_offset err=%b ready=%b valid=%b rd=%b required 1 1 0 0",
                  error_out, item_ready_out, byte_valid_out, hist_rd_en_out);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (wr_count != wr0 || error_out !== 1'b1) begin
         failures++;
         $display("FAIL err_no_bytes bytes=%0d err=%b required bytes=0 err=1", wr_count - wr0, error_out);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < HIST; i++) begin
         mem[i]     = 8'h00;
         mdl_mem[i] = 8'h00;
      end
      hist_rd_data_in = 8'h00;
      mwp = '0;
      test_reset();
      test_literals();
      test_copy_basic();
      test_backpressure();
      test_overlap();
      test_wrap();
      test_reset_midcopy();
      test_after_abort();
`ifdef LZRW1_COPY_CTRL_ERR_CHECK_EN
      test_err_check();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lzrw1_copy_ctrl.md
LZRW1_COPY_CTRL -- requirements
Module: lzrw1_copy_ctrl

Interface
REQ-001 Parameter: HIST_SIZE, 4096, history buffer depth in bytes; ADDR_WIDTH = $clog2(HIST_SIZE).
REQ-002 The block SHALL have these ports:
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-high reset
  item_valid_in  in  1  decoded item available
  item_ready_out  out  1  controller accepts item this cycle
  item_is_copy_in  in  1  1 = copy item, 0 = literal
  literal_in  in  8  literal byte
  offset_in  in  ADDR_WIDTH  copy distance back from write pointer, legal 1..HIST_SIZE-1
  length_in  in  4  LZRW1 length field; copy length = length_in+3 (3..18)
  hist_rd_en_out  out  1  history read strobe
  hist_rd_addr_out  out  ADDR_WIDTH  history read address
  hist_rd_data_in  in  8  read data, valid exactly 1 cycle after hist_rd_en_out
  hist_wr_en_out  out  1  history write strobe
  hist_wr_addr_out  out  ADDR_WIDTH  history write address
  hist_wr_data_out  out  8  history write data
  byte_valid_out  out  1  output byte valid
  byte_ready_in  in  1  downstream accepts byte
  byte_data_out  out  8  output byte
REQ-003 The block SHALL use one clock (clk) and a synchronous active-high reset (reset).

Function
REQ-004 The FSM SHALL have states IDLE, RD, CAP, OUT.
REQ-005 item_ready_out SHALL be 1 only in IDLE; an item is accepted on item_valid_in & item_ready_out.
REQ-006 Literal accepted in cycle t: byte_data_out = literal_in and byte_valid_out = 1 from t+1 (state OUT).
REQ-007 Copy accepted in cycle t: remaining count = length_in+3, read pointer = (wr_ptr - offset_in) mod HIST_SIZE; state RD at t+1.
REQ-008 RD: hist_rd_en_out = 1, hist_rd_addr_out = read pointer, for exactly one cycle; next state CAP.
REQ-009 CAP: hist_rd_data_in SHALL be registered into byte_data_out; next state OUT.
REQ-010 OUT: byte_valid_out = 1; byte_data_out stable until byte_valid_out & byte_ready_in.
REQ-011 On byte acceptance: hist_wr_en_out = 1, hist_wr_addr_out = wr_ptr, hist_wr_data_out = byte_data_out in that same cycle; wr_ptr increments.
REQ-012 After acceptance: copy with remaining > 1 -> decrement remaining, increment read pointer, go to RD; otherwise go to IDLE.
REQ-013 wr_ptr and read pointer SHALL wrap HIST_SIZE-1 -> 0.
REQ-014 Overlapping copies (offset < length) SHALL work: each byte's write precedes the next RD, so offset 1 replicates the previous byte.
REQ-015 Copy throughput SHALL be 1 byte per 3 cycles with byte_ready_in held at 1; literal throughput 1 byte per 2 cycles.
REQ-016 hist_rd_en_out and hist_wr_en_out SHALL never be asserted in the same cycle.

Reset
REQ-017 While reset = 1 on a clock edge: state -> IDLE, wr_ptr = 0, read pointer = 0, remaining = 0.
REQ-018 Reset values of outputs SHALL be: item_ready_out 0 while reset is asserted, then 1 in IDLE; all strobes, byte_valid_out, addresses, and data 0.
REQ-019 Reset mid-copy SHALL abort the item: no further reads or writes, and no partial byte is emitted.

Configuration
REQ-020 Macro LZRW1_COPY_CTRL_ERR_CHECK_EN defined: add output error_out (1 bit, sticky until reset).
REQ-021 With the macro, a copy with offset_in = 0, or offset_in > total bytes written since reset (saturating at HIST_SIZE), SHALL set error_out; the copy SHALL be consumed with no bytes emitted, returning to IDLE the next cycle.
REQ-022 Without the macro, there is no error_out port, and every offset is used modulo HIST_SIZE without checks.

Verification
REQ-023 Reset, then literals 0x41, 0x42, 0x43, byte_ready_in = 1 -> output bytes 41, 42, 43, written at addresses 0, 1, 2, each valid 1 cycle after acceptance.
REQ-024 After 41, 42, 43: copy offset 3, length_in 0 -> output 41, 42, 43, written at addresses 3..5, 3 cycles per byte.
REQ-025 After literal 0x55: copy offset 1, length_in 15 (18 bytes) -> eighteen bytes 0x55; wr_ptr ends at 19.
REQ-026 byte_ready_in low 5 cycles during OUT of a copy -> byte_data_out held stable, one write only, no extra reads.
REQ-027 Preload wr_ptr to 4094 via 4094 literals, then 4 literals -> writes at 4094, 4095, 0, 1; a subsequent copy offset 3 reads addresses 4095, 0, 1.
REQ-028 With LZRW1_COPY_CTRL_ERR_CHECK_EN, after reset, copy offset 5 with 2 bytes written -> error_out = 1, zero bytes emitted, item_ready_out = 1 on the next cycle.
